controller_fsm_mc: RTL and testbench

CONTROLLER_FSM_MC -- requirements
Module: controller_fsm_mc

---
 rtl/ctrl_pkg.sv | 35 +++
 rtl/ctrl_decode.sv | 75 +++++++
 rtl/controller_fsm_mc.sv | 115 +++++++++++
 tb/tb_controller_fsm_mc.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle controller: FSM states, opcode map,
// accumulator source and ALU operation codes.
package ctrl_pkg;

   typedef enum logic [1:0] {
      S_FETCH,
      S_DECODE,
      S_EXECUTE,
      S_HALT
   } state_e;

   localparam logic [3:0] OP_NOP = 4'b0000;
   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_NOR = 4'b0011;
   localparam logic [3:0] OP_LDR = 4'b0100;
   localparam logic [3:0] OP_STR = 4'b0101;
   localparam logic [3:0] OP_JZR = 4'b0110;
   localparam logic [3:0] OP_JZI = 4'b0111;
   localparam logic [3:0] OP_JCR = 4'b1000;
   localparam logic [3:0] OP_JCI = 4'b1010;
   localparam logic [3:0] OP_SHR = 4'b1100;
   localparam logic [3:0] OP_LDI = 4'b1101;
   localparam logic [3:0] OP_HLT = 4'b1111;

   localparam logic [1:0] ACC_ALU = 2'b00;
   localparam logic [1:0] ACC_REG = 2'b01;
   localparam logic [1:0] ACC_IMM = 2'b10;

   localparam logic [3:0] ALU_ADD = OP_ADD;
   localparam logic [3:0] ALU_SUB = OP_SUB;
   localparam logic [3:0] ALU_NOR = OP_NOR;
   localparam logic [3:0] ALU_SHR = OP_SHR;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational decode of the latched opcode into EXECUTE-cycle strobes.
module ctrl_decode
   import ctrl_pkg::*;
#(
   parameter int unsigned OPW  = 4,
   parameter int unsigned ALUW = 4
) (
   input  logic [OPW-1:0]  op_i,
   input  logic            z_i,
   input  logic            c_i,
   output logic            load_pc_o,
   output logic            sel_pc_o,
   output logic            load_reg_o,
   output logic            load_acc_o,
   output logic [1:0]      sel_acc_o,
   output logic [ALUW-1:0] sel_alu_o,
   output logic            halt_o,
   output logic            illegal_o
);

   logic hi_nz;

   generate
      if (OPW > 4) begin : g_wide
         assign hi_nz = |op_i[OPW-1:4];
      end else begin : g_narrow
         assign hi_nz = 1'b0;
      end
   endgenerate

   always_comb begin
      load_pc_o  = 1'b0;
      sel_pc_o   = 1'b0;
      load_reg_o = 1'b0;
      load_acc_o = 1'b0;
      sel_acc_o  = ACC_ALU;
      sel_alu_o  = '0;
      halt_o     = 1'b0;
      illegal_o  = 1'b0;
      if (hi_nz) begin
         illegal_o = 1'b1;
      end else begin
         case (op_i[3:0])
            OP_NOP: ;
            OP_ADD, OP_SUB, OP_NOR, OP_SHR: begin
               load_acc_o     = 1'b1;
               sel_acc_o      = ACC_ALU;
               sel_alu_o[3:0] = op_i[3:0];
            end
            OP_LDR: begin
               load_acc_o = 1'b1;
               sel_acc_o  = ACC_REG;
            end
            OP_LDI: begin
               load_acc_o = 1'b1;
               sel_acc_o  = ACC_IMM;
            end
            OP_STR: load_reg_o = 1'b1;
            OP_JZR: load_pc_o = z_i;
            OP_JZI: begin
               load_pc_o = z_i;
               sel_pc_o  = 1'b1;
            end
            OP_JCR: load_pc_o = c_i;
            OP_JCI: begin
               load_pc_o = c_i;
               sel_pc_o  = 1'b1;
            end
            OP_HLT: halt_o = 1'b1;
            default: illegal_o = 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/controller_fsm_mc.sv
// Multi-cycle FETCH/DECODE/EXECUTE/HALT controller driving datapath strobes.
module controller_fsm_mc
   import ctrl_pkg::*;
#(
   parameter int unsigned OPW          = 4,
   parameter int unsigned ALUW         = 4,
   parameter bit          RUN_ON_RESET = 1'b1
) (
   input  logic            CLK,
   input  logic            CLB,
   input  logic            Z,
   input  logic            C,
   input  logic [OPW-1:0]  Opcode,
   input  logic            MemReady,
   input  logic            Run,
   output logic            LoadIR,
   output logic            IncPC,
   output logic            SelPC,
   output logic            LoadPC,
   output logic            LoadReg,
   output logic            LoadAcc,
   output logic [1:0]      SelAcc,
   output logic [ALUW-1:0] SelALU,
   output logic            Halted,
   output logic            IllegalOp
);

   localparam state_e RST_STATE = RUN_ON_RESET ? S_FETCH : S_HALT;

   state_e         state_q, state_d;
   logic [OPW-1:0] opcode_q;

   logic            dec_load_pc, dec_sel_pc, dec_load_reg, dec_load_acc;
   logic [1:0]      dec_sel_acc;
   logic [ALUW-1:0] dec_sel_alu;
   logic            dec_halt, dec_illegal;

   ctrl_decode #(
      .OPW  (OPW),
      .ALUW (ALUW)
   ) u_decode (
      .op_i       (opcode_q),
      .z_i        (Z),
      .c_i        (C),
      .load_pc_o  (dec_load_pc),
      .sel_pc_o   (dec_sel_pc),
      .load_reg_o (dec_load_reg),
      .load_acc_o (dec_load_acc),
      .sel_acc_o  (dec_sel_acc),
      .sel_alu_o  (dec_sel_alu),
      .halt_o     (dec_halt),
      .illegal_o  (dec_illegal)
   );

   always_ff @(posedge CLK or posedge CLB) begin
      if (CLB) begin
         state_q  <= RST_STATE;
         opcode_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == S_DECODE) opcode_q <= Opcode;
      end
   end

   always_comb begin
      state_d   = state_q;
      LoadIR    = 1'b0;
      IncPC     = 1'b0;
      SelPC     = 1'b0;
      LoadPC    = 1'b0;
      LoadReg   = 1'b0;
      LoadAcc   = 1'b0;
      SelAcc    = '0;
      SelALU    = '0;
      Halted    = 1'b0;
      IllegalOp = 1'b0;
      case (state_q)
         S_FETCH: begin
            LoadIR = MemReady;
            IncPC  = MemReady;
            if (MemReady) state_d = S_DECODE;
         end
         S_DECODE: state_d = S_EXECUTE;
         S_EXECUTE: begin
            SelPC     = dec_sel_pc;
            LoadPC    = dec_load_pc;
            LoadReg   = dec_load_reg;
            LoadAcc   = dec_load_acc;
            SelAcc    = dec_sel_acc;
            SelALU    = dec_sel_alu;
            IllegalOp = dec_illegal;
            state_d   = dec_halt ? S_HALT : S_FETCH;
         end
         S_HALT: begin
            Halted = 1'b1;
            if (Run) state_d = S_FETCH;
         end
         default: state_d = RST_STATE;
      endcase
      // The reset state itself decodes to live strobes, so outputs are masked while CLB is high.
      if (CLB) begin
         LoadIR    = 1'b0;
         IncPC     = 1'b0;
         SelPC     = 1'b0;
         LoadPC    = 1'b0;
         LoadReg   = 1'b0;
         LoadAcc   = 1'b0;
         SelAcc    = '0;
         SelALU    = '0;
         Halted    = 1'b0;
         IllegalOp = 1'b0;
      end
   end

endmodule

// File: tb/tb_controller_fsm_mc.sv
// Scoreboard bench: a default build plus a HALT-on-reset build with a 5-bit opcode.
module tb_controller_fsm_mc;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic       CLB, CLB2, Z, C, MemReady, MemReady2, Run, Run2;
   logic [3:0] Opcode;
   logic [4:0] Opcode2;

   logic       LoadIR1, IncPC1, SelPC1, LoadPC1, LoadReg1, LoadAcc1, Halted1, IllegalOp1;
   logic [1:0] SelAcc1;
   logic [3:0] SelALU1;
   logic       LoadIR2, IncPC2, SelPC2, LoadPC2, LoadReg2, LoadAcc2, Halted2, IllegalOp2;
   logic [1:0] SelAcc2;
   logic [3:0] SelALU2;

   controller_fsm_mc #(.OPW(4), .ALUW(4), .RUN_ON_RESET(1'b1)) u_dut (
      .CLK(CLK), .CLB(CLB), .Z(Z), .C(C), .Opcode(Opcode), .MemReady(MemReady), .Run(Run),
      .LoadIR(LoadIR1), .IncPC(IncPC1), .SelPC(SelPC1), .LoadPC(LoadPC1), .LoadReg(LoadReg1),
      .LoadAcc(LoadAcc1), .SelAcc(SelAcc1), .SelALU(SelALU1), .Halted(Halted1),
      .IllegalOp(IllegalOp1)
   );

   controller_fsm_mc #(.OPW(5), .ALUW(4), .RUN_ON_RESET(1'b0)) u_dut_halt (
      .CLK(CLK), .CLB(CLB2), .Z(Z), .C(C), .Opcode(Opcode2), .MemReady(MemReady2), .Run(Run2),
      .LoadIR(LoadIR2), .IncPC(IncPC2), .SelPC(SelPC2), .LoadPC(LoadPC2), .LoadReg(LoadReg2),
      .LoadAcc(LoadAcc2), .SelAcc(SelAcc2), .SelALU(SelALU2), .Halted(Halted2),
      .IllegalOp(IllegalOp2)
   );

   // {IllegalOp, Halted, SelALU[3:0], SelAcc[1:0], LoadAcc, LoadReg, LoadPC, SelPC, IncPC, LoadIR}
   logic [13:0] obs1, obs2;
   assign obs1 = {IllegalOp1, Halted1, SelALU1, SelAcc1, LoadAcc1, LoadReg1, LoadPC1, SelPC1, IncPC1, LoadIR1};
   assign obs2 = {IllegalOp2, Halted2, SelALU2, SelAcc2, LoadAcc2, LoadReg2, LoadPC2, SelPC2, IncPC2, LoadIR2};

   localparam logic [13:0] ZERO    = 14'h0000;
   localparam logic [13:0] FETCH_V = 14'h0003;
   localparam logic [13:0] HALT_V  = 14'h1000;

   typedef struct {
      string       tag;
      logic [13:0] e1;
      logic [13:0] e2;
   } exp_t;

   typedef struct {
      logic [3:0] op;
      logic       z;
      logic       c;
   } vec_t;

   exp_t        sb_q[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [13:0] other_exp;

   task automatic check(input string tag, input logic [13:0] obs, input logic [13:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [13:0] exec_model(input logic [4:0] op, input logic z, input logic c);
      logic       ill, la, lr, lpc, spc;
      logic [1:0] acc;
      logic [3:0] alu;
      ill = 0; la = 0; lr = 0; lpc = 0; spc = 0; acc = 2'b00; alu = 4'h0;
      if (op[4]) ill = 1;
      else begin
         case (op[3:0])
            4'h1, 4'h2, 4'h3, 4'hC: begin la = 1; alu = op[3:0]; end
            4'h4: begin la = 1; acc = 2'b01; end
            4'hD: begin la = 1; acc = 2'b10; end
            4'h5: lr = 1;
            4'h6: lpc = z;
            4'h7: begin lpc = z; spc = 1; end
            4'h8: lpc = c;
            4'hA: begin lpc = c; spc = 1; end
            4'h9, 4'hB, 4'hE: ill = 1;
            default: ;
         endcase
      end
      return {ill, 1'b0, alu, acc, la, lr, lpc, spc, 1'b0, 1'b0};
   endfunction

   task automatic sb_compare();
      if (sb_q.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL sb_empty: got no entry expected one");
      end else begin
         exp_t e = sb_q.pop_front();
         check({e.tag, "/dut"}, obs1, e.e1);
         check({e.tag, "/alt"}, obs2, e.e2);
      end
   endtask

   task automatic step(input string tag, input logic [13:0] e1, input logic [13:0] e2);
      sb_q.push_back('{tag, e1, e2});
      @(negedge CLK);
      sb_compare();
      @(posedge CLK);
      #1;
   endtask

   task automatic probe(input string tag, input logic [13:0] e1, input logic [13:0] e2);
      sb_q.push_back('{tag, e1, e2});
      #1;
      sb_compare();
   endtask

   task automatic drive(input bit alt, input logic mr, input logic [4:0] op);
      if (alt) begin MemReady2 = mr; Opcode2 = op; end
      else begin MemReady = mr; Opcode = op[3:0]; end
   endtask

   task automatic instr(input bit alt, input logic [4:0] op, input logic z, input logic c,
                        input int unsigned waits, input string tag);
      logic [13:0] o = other_exp;
      logic [13:0] e = exec_model(op, z, c);
      for (int unsigned i = 0; i < waits; i++) begin
         drive(alt, 1'b0, op);
         step({tag, "_wait"}, alt ? o : ZERO, alt ? ZERO : o);
      end
      drive(alt, 1'b1, op);
      step({tag, "_fetch"}, alt ? o : FETCH_V, alt ? FETCH_V : o);
      Z = ~z; C = ~c;
      step({tag, "_decode"}, alt ? o : ZERO, alt ? ZERO : o);
      drive(alt, 1'b1, ~op & (alt ? 5'h1F : 5'h0F));
      Z = z; C = c;
      step({tag, "_exec"}, alt ? o : e, alt ? e : o);
   endtask

   vec_t tbl [17] = '{
      '{4'h3, 1'b0, 1'b0}, '{4'hC, 1'b0, 1'b0}, '{4'h4, 1'b0, 1'b0}, '{4'hD, 1'b0, 1'b0},
      '{4'h5, 1'b0, 1'b0}, '{4'h6, 1'b1, 1'b0}, '{4'h6, 1'b0, 1'b1}, '{4'h7, 1'b1, 1'b0},
      '{4'h7, 1'b0, 1'b0}, '{4'h8, 1'b0, 1'b1}, '{4'h8, 1'b1, 1'b0}, '{4'hA, 1'b1, 1'b0},
      '{4'hA, 1'b0, 1'b1}, '{4'h9, 1'b1, 1'b1}, '{4'hB, 1'b0, 1'b0}, '{4'hE, 1'b1, 1'b1},
      '{4'h0, 1'b1, 1'b1}
   };

   initial begin
      CLB = 1'b1; CLB2 = 1'b1; Z = 1'b0; C = 1'b0; Run = 1'b0; Run2 = 1'b0;
      MemReady = 1'b1; MemReady2 = 1'b0; Opcode = 4'h1; Opcode2 = 5'h00;
      other_exp = HALT_V;
      repeat (2) @(posedge CLK);
      #1;
      step("in_reset", ZERO, ZERO);
      CLB = 1'b0; CLB2 = 1'b0;

      instr(1'b0, 5'h01, 1'b0, 1'b0, 0, "add");
      instr(1'b0, 5'h02, 1'b0, 1'b0, 4, "sub_memwait");
      Run = 1'b1;
      instr(1'b0, 5'h0D, 1'b0, 1'b0, 0, "ldi_run_ignored");
      Run = 1'b0;
      foreach (tbl[k])
         instr(1'b0, {1'b0, tbl[k].op}, tbl[k].z, tbl[k].c, 0, $sformatf("op%h_z%0d_c%0d", tbl[k].op, tbl[k].z, tbl[k].c));

      instr(1'b0, 5'h0F, 1'b0, 1'b0, 0, "hlt");
      MemReady = 1'b1;
      for (int i = 0; i < 10; i++) step($sformatf("halted%0d", i), HALT_V, HALT_V);

      Run2 = 1'b1;
      step("alt_run", HALT_V, HALT_V);
      Run2 = 1'b0;
      instr(1'b1, 5'h11, 1'b0, 1'b0, 0, "alt_hibit_add");
      instr(1'b1, 5'h1F, 1'b0, 1'b0, 0, "alt_hibit_hlt");
      instr(1'b1, 5'h0C, 1'b0, 1'b0, 0, "alt_shr");
      MemReady2 = 1'b0;
      step("alt_not_halted", HALT_V, ZERO);

      Run = 1'b1;
      step("run_pulse", HALT_V, ZERO);
      Run = 1'b0;
      other_exp = ZERO;
      instr(1'b0, 5'h01, 1'b0, 1'b0, 0, "add_after_run");

      MemReady = 1'b1; Opcode = 4'h5;
      step("str_fetch", FETCH_V, ZERO);
      step("str_decode", ZERO, ZERO);
      Opcode = 4'h0;
      sb_q.push_back('{"str_exec", exec_model(5'h05, 1'b0, 1'b0), ZERO});
      @(negedge CLK);
      sb_compare();
      #1;
      CLB = 1'b1; CLB2 = 1'b1;
      probe("async_reset", ZERO, ZERO);
      @(posedge CLK);
      #1;
      step("held_reset", ZERO, ZERO);
      CLB = 1'b0; CLB2 = 1'b0; MemReady = 1'b0;
      step("post_reset", ZERO, HALT_V);
      MemReady = 1'b1;
      step("post_reset_fetch", FETCH_V, HALT_V);

      if (sb_q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL sb_leftover: got %0d entries expected 0", sb_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule
